// File: rtl/row_clear_engine.sv
// Removes full rows from an external board register file. Each cleared row shifts the rows above
// it down one place, and the board is then rescanned bottom-up for any further full rows.
module row_clear_engine #(
    parameter int ROWS   = 11,
    parameter int COLS   = 8,
    parameter int ROW_W  = 4,
    parameter int NO_ROW = 11
) (
    input  logic             clka,
    input  logic             restart,
    input  logic             start_clear,
    input  logic [ROW_W-1:0] which_row,
    output logic [ROW_W-1:0] rd_addr,
    input  logic [COLS-1:0]  rd_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_addr,
    output logic [COLS-1:0]  wr_data,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] lines_cleared
);

    localparam logic [ROW_W-1:0] ROWS_W   = ROW_W'(ROWS);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] NO_ROW_W = ROW_W'(NO_ROW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_SCAN,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] ptr;
    logic [ROW_W-1:0] scan_ptr;
    logic             row_full;
    logic             valid_row;

    assign row_full  = &rd_data;
    assign valid_row = (which_row < ROWS_W) && (which_row != NO_ROW_W);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            state         <= S_IDLE;
            ptr           <= '0;
            scan_ptr      <= '0;
            lines_cleared <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_clear) begin
                        if (valid_row) begin
                            ptr           <= which_row;
                            lines_cleared <= ROW_W'(1);
                            state         <= S_SHIFT;
                        end else begin
                            lines_cleared <= '0;
                            state         <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (ptr != '0) begin
                        ptr <= ptr - 1'b1;
                    end else begin
                        scan_ptr <= LAST_ROW;
                        state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Restart from the bottom after every shift so stacked full rows are caught.
                    if (row_full) begin
                        ptr <= scan_ptr;
                        if (lines_cleared != ROWS_W)
                            lines_cleared <= lines_cleared + 1'b1;
                        state <= S_SHIFT;
                    end else if (scan_ptr == '0) begin
                        state <= S_DONE;
                    end else begin
                        scan_ptr <= scan_ptr - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= start_clear ? S_WAIT_LOW : S_IDLE;
                end
                S_WAIT_LOW: begin
                    if (!start_clear)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state)
            S_SHIFT: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                // At ptr==0 the top row is blanked rather than copied.
                if (ptr != '0) begin
                    rd_addr = ptr - 1'b1;
                    wr_data = rd_data;
                end
            end
            S_SCAN: begin
                rd_addr = scan_ptr;
            end
            default: ;
        endcase
    end

    assign busy = (state == S_SHIFT) || (state == S_SCAN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_row_clear_engine.sv
// Directed bench for row_clear_engine: models the board register file and checks
// board contents, done latency, pulse counts and reset behaviour against hand-computed values.
module tb_row_clear_engine;

    localparam int ROWS  = 11;
    localparam int COLS  = 8;
    localparam int ROW_W = 4;

    logic             clka = 1'b0;
    logic             restart;
    logic             start_clear;
    logic [ROW_W-1:0] which_row;
    logic [ROW_W-1:0] rd_addr;
    logic [COLS-1:0]  rd_data;
    logic             wr_en;
    logic [ROW_W-1:0] wr_addr;
    logic [COLS-1:0]  wr_data;
    logic             busy;
    logic             done;
    logic [ROW_W-1:0] lines_cleared;

    logic [COLS-1:0]  board [0:15];
    logic             ld_en;
    logic [ROW_W-1:0] ld_addr;
    logic [COLS-1:0]  ld_data;

    int wr_count   = 0;
    int done_count = 0;
    int pass_count = 0;
    int check_count = 0;

    row_clear_engine #(.ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .NO_ROW(11)) dut (
        .clka          (clka),
        .restart       (restart),
        .start_clear   (start_clear),
        .which_row     (which_row),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    always #5 clka = ~clka;

    // Board register file: combinational read, synchronous write; the bench preloads through ld_*.
    assign rd_data = board[rd_addr];

    always @(posedge clka) begin
        if (wr_en) begin
            board[wr_addr] <= wr_data;
            wr_count       <= wr_count + 1;
        end else if (ld_en) begin
            board[ld_addr] <= ld_data;
        end
        if (done)
            done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp)
            pass_count++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic load_row(input int r, input logic [COLS-1:0] d);
        ld_en   = 1'b1;
        ld_addr = r[ROW_W-1:0];
        ld_data = d;
        tick();
        ld_en   = 1'b0;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 16; i++)
            load_row(i, '0);
    endtask

    // One-cycle start pulse; lat = posedges after the accept edge until done is seen, -1 on timeout.
    task automatic run_clear(input logic [ROW_W-1:0] row, output int lat);
        which_row   = row;
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        lat = -1;
        for (int n = 0; n < 200; n++) begin
            if (done) begin
                lat = n;
                break;
            end
            tick();
        end
    endtask

    int lat;
    int w0;
    int d0;
    logic [COLS-1:0] acc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        restart     = 1'b1;
        start_clear = 1'b0;
        which_row   = '0;
        ld_en       = 1'b0;
        ld_addr     = '0;
        ld_data     = '0;
        repeat (2) tick();

        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_wr_en", wr_en, 0);
        check("reset_rd_addr", rd_addr, 0);
        check("reset_wr_addr", wr_addr, 0);
        check("reset_wr_data", wr_data, 0);
        check("reset_lines", lines_cleared, 0);
        restart = 1'b0;
        tick();

        // Single clear of the bottom row.
        clear_board();
        load_row(10, 8'hFF);
        load_row(9, 8'h0F);
        w0 = wr_count;
        run_clear(4'd10, lat);
        check("single_latency", lat, 22);
        check("single_lines", lines_cleared, 1);
        check("single_busy_in_done", busy, 0);
        tick();
        check("single_done_pulse_len", done, 0);
        check("single_row10", board[10], 8'h0F);
        check("single_row9", board[9], 8'h00);
        check("single_row0", board[0], 8'h00);
        check("single_writes", wr_count - w0, 11);

        // Two stacked full rows.
        clear_board();
        load_row(10, 8'hFF);
        load_row(9, 8'hFF);
        load_row(8, 8'h81);
        d0 = done_count;
        run_clear(4'd10, lat);
        check("stacked_latency", lat, 34);
        check("stacked_lines", lines_cleared, 2);
        repeat (3) tick();
        check("stacked_row10", board[10], 8'h81);
        acc = '0;
        for (int i = 0; i < 10; i++)
            acc = acc | board[i];
        check("stacked_rows0to9", acc, 0);
        check("stacked_done_count", done_count - d0, 1);

        // No row to clear.
        w0 = wr_count;
        run_clear(4'd11, lat);
        check("norow_latency", lat, 0);
        check("norow_lines", lines_cleared, 0);
        tick();
        check("norow_writes", wr_count - w0, 0);

        // Top row only.
        clear_board();
        load_row(0, 8'hFF);
        w0 = wr_count;
        run_clear(4'd0, lat);
        check("top_latency", lat, 12);
        check("top_lines", lines_cleared, 1);
        repeat (3) tick();
        check("top_row0", board[0], 8'h00);
        check("top_writes", wr_count - w0, 1);
        check("top_lines_held", lines_cleared, 1);

        // Level-held start_clear yields exactly one operation.
        clear_board();
        load_row(10, 8'hFF);
        d0 = done_count;
        which_row   = 4'd10;
        start_clear = 1'b1;
        repeat (40) tick();
        check("hold_done_count", done_count - d0, 1);
        check("hold_busy", busy, 0);
        check("hold_done_low", done, 0);
        check("hold_row10", board[10], 8'h00);
        start_clear = 1'b0;
        tick();
        which_row   = 4'd11;
        start_clear = 1'b1;
        tick();
        check("hold_reaccept_done", done, 1);
        check("hold_reaccept_lines", lines_cleared, 0);
        start_clear = 1'b0;
        tick();
        check("hold_done_count2", done_count - d0, 2);

        // Asynchronous reset in the middle of a shift.
        clear_board();
        load_row(10, 8'hFF);
        which_row   = 4'd10;
        start_clear = 1'b1;
        tick();
        start_clear = 1'b0;
        repeat (5) tick();
        check("mid_wr_en", wr_en, 1);
        check("mid_wr_addr", wr_addr, 5);
        check("mid_rd_addr", rd_addr, 4);
        check("mid_busy", busy, 1);
        restart = 1'b1;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_lines", lines_cleared, 0);
        #2;
        restart = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_wr_en", wr_en, 0);
        check("post_rst_lines", lines_cleared, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
